data_mem_lsu: RTL and testbench

Load/store unit sitting between the pipeline's memory stage and `Memory_Data`. It accepts one byte/halfword/word load or store request at a time over a valid/ready handshake and drives `RAA`/`MW`/`datain` into the data memory. Sub-word stores use read-modify-write, and loads are returned sign- or zero-extended. It is the initiator for `Memory_Data`: `Memory_Data` reads combinationally (`dataout` follows `RAA` in the same cycle) and writes on the rising edge of `clk` when `MW`=1.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_lane.sv | 36 +++
 rtl/data_mem_lsu.sv | 124 ++++++++++++
 tb/tb_data_mem_lsu.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StResp
  } lsu_state_e;

  // True when the request can never reach memory (bad size or misaligned lane).
  function automatic logic req_is_err(input logic [1:0] size, input logic [1:0] off);
    logic err;
    unique case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = off[0];
      SZ_WORD: err = (off != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane logic: sub-word store merge and load extract/extend.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        size,
  input  logic [1:0]        off,
  input  logic              is_signed,
  output logic [DATA_W-1:0] merged,
  output logic [DATA_W-1:0] rdata
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    merged = old_word;
    unique case (size)
      SZ_BYTE: merged[{off, 3'b000} +: 8]       = wdata[7:0];
      SZ_HALF: merged[{off[1], 4'b0000} +: 16]  = wdata[15:0];
      default: merged = wdata;
    endcase
  end

  always_comb begin
    ld_byte = old_word[{off, 3'b000} +: 8];
    ld_half = old_word[{off[1], 4'b0000} +: 16];
    unique case (size)
      SZ_BYTE: rdata = {{24{is_signed & ld_byte[7]}}, ld_byte};
      SZ_HALF: rdata = {{16{is_signed & ld_half[15]}}, ld_half};
      default: rdata = old_word;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit driving a combinational-read, edge-write data memory.
// One request in flight; sub-word stores are read-modify-write.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W+1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   RAA,
  output logic                MW,
  output logic [DATA_W-1:0]   datain,
  input  logic [DATA_W-1:0]   dataout
);

  lsu_state_e          state_q;
  logic                we_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic [DATA_W-1:0]   merged;
  logic [DATA_W-1:0]   loaded;
  logic                req_err;

  assign req_err = req_is_err(req_size, req_addr[1:0]);

  lsu_lane u_lane (
    .old_word  (dataout),
    .wdata     (wdata_q),
    .size      (size_q),
    .off       (addr_q[1:0]),
    .is_signed (signed_q),
    .merged    (merged),
    .rdata     (loaded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
            err_q    <= req_err;
            if (req_err) begin
              state_q <= StResp;
            end else if (req_we && (req_size == SZ_WORD)) begin
              state_q <= StWrite;
            end else begin
              // Loads and sub-word stores both need the current word first.
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          if (we_q) begin
            wdata_q <= merged;
            state_q <= StWrite;
          end else begin
            rdata_q <= loaded;
            state_q <= StResp;
          end
        end
        StWrite: begin
          state_q <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory port is decoded from registered state only, so reset kills MW at once.
  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
    MW        = (state_q == StWrite);
    RAA       = '0;
    datain    = '0;
    if ((state_q == StRead) || (state_q == StWrite)) begin
      RAA = addr_q[ADDR_W+1:2];
    end
    if (state_q == StWrite) begin
      datain = wdata_q;
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench: data_mem_lsu paired with a behavioural data memory,
// checked cycle by cycle against a byte-level reference model.
module tb_data_mem_lsu;

  localparam int unsigned AW = 7;
  localparam int unsigned NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_signed = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] RAA;
  logic          MW;
  logic [31:0]   datain;
  logic [31:0]   dataout;

  always #5 clk = ~clk;

  data_mem_lsu #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .RAA        (RAA),
    .MW         (MW),
    .datain     (datain),
    .dataout    (dataout)
  );

  // Memory_Data stand-in: combinational read, write on rising edge.
  logic [31:0] mem     [NW];
  logic [31:0] ref_mem [NW];
  logic        do_load = 1'b0;

  assign dataout = mem[RAA];

  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < NW; i++) mem[i] <= ref_mem[i];
    end else if (MW) begin
      mem[RAA] <= datain;
    end
  end

  // Model of the request in flight; k counts edges since the accept edge.
  bit          busy = 1'b0;
  bit          chk_en = 1'b0;
  int          k = 0;
  int          lat_k = 0, rd_k = -1, mw_k = -1;
  logic        exp_err;
  logic [31:0] exp_rdata, exp_word;
  logic [AW-1:0] exp_waddr;

  int checks = 0;
  int errors = 0;
  int mw_cnt = 0;

  typedef struct {
    string       name;
    logic [31:0] got;
    logic [31:0] exp;
  } chk_t;
  chk_t pend[$];

  function automatic void post(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.got  = got;
    c.exp  = exp;
    pend.push_back(c);
  endfunction

  task automatic do_chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk or posedge do_load) begin
    chk_t c;
    bit   vexp, mexp, aexp;
    if (!do_load) begin
      if (MW) mw_cnt++;
      if (chk_en) begin
        vexp = busy && (k >= lat_k);
        mexp = busy && (k == mw_k);
        aexp = busy && ((k == rd_k) || (k == mw_k));
        do_chk("req_ready", 32'(req_ready), 32'(!busy));
        do_chk("rsp_valid", 32'(rsp_valid), 32'(vexp));
        if (vexp) begin
          do_chk("rsp_err", 32'(rsp_err), 32'(exp_err));
          do_chk("rsp_rdata", rsp_rdata, exp_rdata);
        end
        do_chk("MW", 32'(MW), 32'(mexp));
        do_chk("RAA", 32'(RAA), aexp ? 32'(exp_waddr) : 32'd0);
        do_chk("datain", datain, mexp ? exp_word : 32'd0);
      end
    end
    while (pend.size() > 0) begin
      c = pend.pop_front();
      do_chk(c.name, c.got, c.exp);
    end
  end

  // Expected behaviour from byte-lane arithmetic on the reference memory.
  task automatic setup_model(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [AW+1:0] addr, input logic [31:0] wdata);
    int          nb, sh;
    logic [31:0] old, mask, lane;
    logic [1:0]  off;
    logic        err;
    off  = addr[1:0];
    err  = (size == 2'd3) || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);
    nb   = 1 << size;
    sh   = 8 * int'(off);
    old  = ref_mem[addr[AW+1:2]];
    mask = (nb >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    lane = (old >> sh) & mask;
    if (sgn && nb < 4 && lane[8 * nb - 1]) lane = lane | ~mask;
    exp_word  = (old & ~(mask << sh)) | ((wdata & mask) << sh);
    exp_err   = err;
    exp_rdata = (err || we) ? 32'd0 : lane;
    exp_waddr = addr[AW+1:2];
    if (err) begin
      lat_k = 0; rd_k = -1; mw_k = -1;
    end else if (!we) begin
      lat_k = 1; rd_k = 0; mw_k = -1;
    end else if (size == 2'd2) begin
      lat_k = 1; rd_k = -1; mw_k = 0;
    end else begin
      lat_k = 2; rd_k = 0; mw_k = 1;
    end
  endtask

  task automatic sync_mem();
    @(negedge clk);
    do_load = 1'b1;
    @(posedge clk);
    #1 do_load = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [AW+1:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    setup_model(we, size, sgn, addr, wdata);
    @(posedge clk);
    busy = 1'b1;
    k = 0;
    #1 req_valid = 1'b0;
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [AW+1:0] addr, input logic [31:0] wdata,
                         input int delay, output logic [31:0] got_rdata,
                         output logic got_err, output int mw_seen);
    int mw_base;
    mw_base = mw_cnt;
    issue(we, size, sgn, addr, wdata);
    while (k < lat_k) begin
      @(posedge clk);
      k++;
    end
    repeat (delay) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    busy = 1'b0;
    if (!exp_err && we) ref_mem[exp_waddr] = exp_word;
    #1 rsp_ready = 1'b0;
    mw_seen = mw_cnt - mw_base;
    post("mem_word", mem[exp_waddr], ref_mem[exp_waddr]);
  endtask

  initial begin
    logic [31:0] r, w0;
    logic        e;
    int          n, sz;
    logic [1:0]  size;
    logic [AW+1:0] addr;

    for (int i = 0; i < NW; i++) ref_mem[i] = $urandom;
    sync_mem();

    // Reset values, and a request held during reset must not be taken.
    post("rst_req_ready", 32'(req_ready), 32'd1);
    post("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    post("rst_rsp_rdata", rsp_rdata, 32'd0);
    post("rst_rsp_err", 32'(rsp_err), 32'd0);
    post("rst_MW", 32'(MW), 32'd0);
    post("rst_RAA", 32'(RAA), 32'd0);
    post("rst_datain", datain, 32'd0);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = '0; req_wdata = 32'h0BAD_0BAD;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    post("rst_no_capture", mem[0], ref_mem[0]);

    // Word store / load.
    run_req(1'b1, 2'd2, 1'b0, 9'h014, 32'hDEAD_BEEF, 0, r, e, n);
    post("ws_mem5", mem[5], 32'hDEAD_BEEF);
    post("ws_mw_cycles", 32'(n), 32'd1);
    run_req(1'b0, 2'd2, 1'b0, 9'h014, 32'h0, 0, r, e, n);
    post("wl_rdata", r, 32'hDEAD_BEEF);
    post("wl_err", 32'(e), 32'd0);

    // Byte read-modify-write with junk in the upper store bits.
    ref_mem[5] = 32'h1122_3344;
    sync_mem();
    run_req(1'b1, 2'd0, 1'b0, 9'h016, 32'h1234_56AA, 0, r, e, n);
    post("rmw_mem5", mem[5], 32'h11AA_3344);
    post("rmw_mw_cycles", 32'(n), 32'd1);

    // Extension.
    ref_mem[10] = 32'h0000_F080;
    sync_mem();
    run_req(1'b0, 2'd0, 1'b1, 9'h028, 32'h0, 0, r, e, n);
    post("lb_signed", r, 32'hFFFF_FF80);
    run_req(1'b0, 2'd0, 1'b0, 9'h028, 32'h0, 1, r, e, n);
    post("lb_unsigned", r, 32'h0000_0080);
    run_req(1'b0, 2'd1, 1'b1, 9'h028, 32'h0, 0, r, e, n);
    post("lh_signed", r, 32'hFFFF_F080);

    // Errors.
    run_req(1'b0, 2'd1, 1'b0, 9'h029, 32'h0, 0, r, e, n);
    post("err_half_err", 32'(e), 32'd1);
    post("err_half_rdata", r, 32'd0);
    run_req(1'b1, 2'd2, 1'b0, 9'h02A, 32'hCAFE_F00D, 0, r, e, n);
    post("err_wst_err", 32'(e), 32'd1);
    post("err_wst_mw", 32'(n), 32'd0);
    post("err_wst_mem10", mem[10], 32'h0000_F080);
    run_req(1'b1, 2'd3, 1'b0, 9'h028, 32'h5555_5555, 2, r, e, n);
    post("err_size_err", 32'(e), 32'd1);
    post("err_size_mw", 32'(n), 32'd0);

    // Backpressure and top-address byte store.
    run_req(1'b0, 2'd2, 1'b0, 9'h014, 32'h0, 5, r, e, n);
    post("bp_rdata", r, 32'h11AA_3344);
    w0 = mem[0];
    run_req(1'b1, 2'd0, 1'b0, 9'h1FF, 32'h0000_005A, 0, r, e, n);
    post("top_byte", {24'd0, mem[127][31:24]}, 32'h0000_005A);
    post("top_word0", mem[0], w0);

    // Reset while the RMW store sits in WRITE.
    issue(1'b1, 2'd0, 1'b0, 9'h030, 32'h0000_00C3);
    @(posedge clk);
    k = 1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    busy = 1'b0;
    #1;
    post("mid_rst_MW", 32'(MW), 32'd0);
    post("mid_rst_RAA", 32'(RAA), 32'd0);
    post("mid_rst_datain", datain, 32'd0);
    post("mid_rst_ready", 32'(req_ready), 32'd1);
    post("mid_rst_valid", 32'(rsp_valid), 32'd0);
    post("mid_rst_rdata", rsp_rdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    post("mid_rst_mem12", mem[12], ref_mem[12]);
    rst_n = 1'b1;
    run_req(1'b1, 2'd1, 1'b0, 9'h032, 32'h0000_BEEF, 0, r, e, n);
    post("post_rst_mem12", mem[12], {16'hBEEF, ref_mem[12][15:0]});

    // Randomised traffic.
    for (int t = 0; t < 250; t++) begin
      sz   = int'($urandom % 8);
      size = (sz < 7) ? 2'(sz % 3) : 2'd3;
      addr = (AW + 2)'($urandom);
      if ($urandom % 4 != 0) begin
        if (size == 2'd1) addr[0] = 1'b0;
        if (size == 2'd2) addr[1:0] = 2'b00;
      end
      run_req(1'($urandom), size, 1'($urandom), addr, $urandom, int'($urandom % 4), r, e, n);
    end

    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
